// File: rtl/rr_requester.sv
// Round-robin requester: queues job length codes, requests the shared arbiter per job,
// streams job_len+1 beats while granted and leaves req low between jobs so priority can rotate.
//
// state  | meaning
// IDLE   | no job in flight, req low; leaves as soon as the queue holds a job
// REQ    | req high, waiting for gnt; wait counter runs toward TIMEOUT
// XFER   | req high, one beat per granted cycle until the beat counter is spent
// GAP    | req low for GAP cycles after a job so the arbiter can rotate
module rr_requester #(
   parameter int DEPTH   = 4,
   parameter int GAP     = 1,
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       job_valid,
   input  logic [3:0] job_len,
   output logic       job_ready,
   output logic       req,
   input  logic       gnt,
   output logic       beat,
   output logic       done,
   output logic       busy,
   output logic       timeout_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int WW = $clog2(TIMEOUT + 1);

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT);
   localparam logic [2:0]    GAP_LOAD = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_XFER,
      S_GAP
   } state_t;

   state_t        state_q, state_d;
   logic          req_q, req_d;
   logic          done_q, done_d;
   logic          terr_q, terr_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [3:0]    beat_cnt_q, beat_cnt_d;
   logic [2:0]    gap_cnt_q, gap_cnt_d;

   logic [3:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          full, empty, push, pop;
   logic [3:0]    head_len;

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign push      = job_valid & ~full & ~rst;
   assign head_len  = mem[rd_ptr];

   assign job_ready   = rst | ~full;
   assign req         = req_q;
   assign done        = done_q;
   assign timeout_err = terr_q;
   assign beat        = ~rst & (state_q == S_XFER) & gnt;
   assign busy        = ~rst & ((state_q != S_IDLE) | ~empty);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= job_len;
      end
   end

   // a full queue refuses the push even when the head pops on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      done_d     = 1'b0;
      wait_d     = wait_q;
      beat_cnt_d = beat_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      pop        = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            req_d = 1'b0;
            if (!empty) begin
               state_d = S_REQ;
               req_d   = 1'b1;
               wait_d  = '0;
            end
         end

         // req_q is low here only on the cycle right after a GAP=0 job end;
         // that cycle is the mandatory req-low slot, so gnt is ignored
         S_REQ: begin
            req_d = 1'b1;
            if (req_q && gnt) begin
               state_d    = S_XFER;
               beat_cnt_d = head_len;
               wait_d     = '0;
            end else if (req_q && (wait_q != WAIT_MAX)) begin
               wait_d = wait_q + 1'b1;
            end
         end

         S_XFER: begin
            req_d = 1'b1;
            if (gnt) begin
               if (beat_cnt_q == 4'd0) begin
                  pop    = 1'b1;
                  done_d = 1'b1;
                  req_d  = 1'b0;
                  if (GAP > 0) begin
                     state_d   = S_GAP;
                     gap_cnt_d = GAP_LOAD;
                  end else if ((count > CW'(1)) || push) begin
                     state_d = S_REQ;
                     wait_d  = '0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  beat_cnt_d = beat_cnt_q - 1'b1;
               end
            end
         end

         S_GAP: begin
            req_d = 1'b0;
            if (gap_cnt_q == 3'd0) begin
               if (!empty) begin
                  state_d = S_REQ;
                  req_d   = 1'b1;
                  wait_d  = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q - 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
         end
      endcase

      terr_d = terr_q | (wait_d == WAIT_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         req_q      <= 1'b0;
         done_q     <= 1'b0;
         terr_q     <= 1'b0;
         wait_q     <= '0;
         beat_cnt_q <= '0;
         gap_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         done_q     <= done_d;
         terr_q     <= terr_d;
         wait_q     <= wait_d;
         beat_cnt_q <= beat_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

endmodule

// File: tb/tb_rr_requester.sv
// Bench for rr_requester: default instance plus a GAP=2 instance sharing stimulus.
// Output vector order in tables: {req, beat, done, busy, job_ready, timeout_err}.
module tb_rr_requester;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, job_valid, gnt;
   logic [3:0] job_len;

   logic job_ready0, req0, beat0, done0, busy0, terr0;
   logic job_ready1, req1, beat1, done1, busy1, terr1;

   rr_requester u_dut (
      .clk         (clk),
      .rst         (rst),
      .job_valid   (job_valid),
      .job_len     (job_len),
      .job_ready   (job_ready0),
      .req         (req0),
      .gnt         (gnt),
      .beat        (beat0),
      .done        (done0),
      .busy        (busy0),
      .timeout_err (terr0)
   );

   rr_requester #(.DEPTH(4), .GAP(2), .TIMEOUT(16)) u_gap2 (
      .clk         (clk),
      .rst         (rst),
      .job_valid   (job_valid),
      .job_len     (job_len),
      .job_ready   (job_ready1),
      .req         (req1),
      .gnt         (gnt),
      .beat        (beat1),
      .done        (done1),
      .busy        (busy1),
      .timeout_err (terr1)
   );

   typedef struct {
      bit         unit;
      bit         rst;
      bit         jv;
      logic [3:0] len;
      bit         gnt;
      logic [5:0] exp;
   } vec_t;

   typedef struct {
      int         idx;
      bit         unit;
      logic [5:0] exp;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   int   beats, dones, busy_seen, n;

   function automatic logic [5:0] outs(input bit unit);
      if (unit) return {req1, beat1, done1, busy1, job_ready1, terr1};
      return {req0, beat0, done0, busy0, job_ready0, terr0};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic add(input bit u, input bit r, input bit v, input logic [3:0] l,
                      input bit g, input logic [5:0] x);
      vec_t t;
      t.unit = u; t.rst = r; t.jv = v; t.len = l; t.gnt = g; t.exp = x;
      vecs.push_back(t);
   endtask

   task automatic drive(input bit r, input bit v, input logic [3:0] l, input bit g);
      @(negedge clk);
      rst = r; job_valid = v; job_len = l; gnt = g;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; job_valid = 1'b0; job_len = 4'd0; gnt = 1'b0;
      repeat (2) @(posedge clk);

      // single job len 2, gnt tied high
      add(0,1,0,4'd0,1,6'b000010);
      add(0,0,1,4'd2,1,6'b000010);
      add(0,0,0,4'd0,1,6'b000110);
      add(0,0,0,4'd0,1,6'b100110);
      add(0,0,0,4'd0,1,6'b110110);
      add(0,0,0,4'd0,1,6'b110110);
      add(0,0,0,4'd0,1,6'b110110);
      add(0,0,0,4'd0,1,6'b001110);
      add(0,0,0,4'd0,1,6'b000010);
      add(0,0,0,4'd0,1,6'b000010);
      // stalled grant, len 3, XFER gnt 1,1,0,0,1,1
      add(0,1,0,4'd0,0,6'b000010);
      add(0,0,1,4'd3,0,6'b000010);
      add(0,0,0,4'd0,0,6'b000110);
      add(0,0,0,4'd0,1,6'b100110);
      add(0,0,0,4'd0,1,6'b110110);
      add(0,0,0,4'd0,1,6'b110110);
      add(0,0,0,4'd0,0,6'b100110);
      add(0,0,0,4'd0,0,6'b100110);
      add(0,0,0,4'd0,1,6'b110110);
      add(0,0,0,4'd0,1,6'b110110);
      add(0,0,0,4'd0,0,6'b001110);
      add(0,0,0,4'd0,0,6'b000010);
      // fill to full, refused 5th, then reset with a full queue and job_valid high
      add(0,1,0,4'd0,0,6'b000010);
      add(0,0,1,4'd1,0,6'b000010);
      add(0,0,1,4'd2,0,6'b000110);
      add(0,0,1,4'd3,0,6'b100110);
      add(0,0,1,4'd4,0,6'b100110);
      add(0,0,1,4'd5,0,6'b100100);
      add(0,1,1,4'd6,1,6'b100010);
      add(0,0,0,4'd0,1,6'b000010);
      add(0,0,0,4'd0,1,6'b000010);
      // GAP=2 instance: two jobs (len 0, len 1), gnt tied high
      add(1,1,0,4'd0,1,6'b000010);
      add(1,0,1,4'd0,1,6'b000010);
      add(1,0,1,4'd1,1,6'b000110);
      add(1,0,0,4'd0,1,6'b100110);
      add(1,0,0,4'd0,1,6'b110110);
      add(1,0,0,4'd0,1,6'b001110);
      add(1,0,0,4'd0,1,6'b000110);
      add(1,0,0,4'd0,1,6'b100110);
      add(1,0,0,4'd0,1,6'b110110);
      add(1,0,0,4'd0,1,6'b110110);
      add(1,0,0,4'd0,1,6'b001110);
      add(1,0,0,4'd0,1,6'b000110);
      add(1,0,0,4'd0,1,6'b000010);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst = vecs[i].rst; job_valid = vecs[i].jv; job_len = vecs[i].len; gnt = vecs[i].gnt;
         e.idx = i; e.unit = vecs[i].unit; e.exp = vecs[i].exp;
         sb.push_back(e);
         #1;
         e = sb.pop_front();
         check($sformatf("vec%0d_u%0d", e.idx, e.unit), 32'(outs(e.unit)), 32'(e.exp));
      end

      // queue full: five offers with gnt low, then drain and count what was stored
      drive(1, 0, 4'd0, 0);
      for (int k = 0; k < 5; k++) begin
         drive(0, 1, 4'(k + 1), 0);
         if (k == 3) check("full_ready_4th", job_ready0, 1);
         if (k == 4) check("full_ready_5th", job_ready0, 0);
      end
      beats = 0; dones = 0;
      for (int c = 0; c < 100; c++) begin
         drive(0, 0, 4'd0, 1);
         beats += int'(beat0);
         dones += int'(done0);
         if (!busy0) break;
      end
      check("full_drain_idle", busy0, 0);
      check("full_drain_dones", dones, 4);
      check("full_drain_beats", beats, 14);

      // timeout: 16 unanswered req cycles, then grant; flag sticks until rst
      drive(1, 0, 4'd0, 0);
      drive(0, 1, 4'd1, 0);
      n = 0;
      while (!req0 && n < 10) begin
         drive(0, 0, 4'd0, 0);
         n++;
      end
      check("to_req_up", req0, 1);
      for (int i = 1; i <= 16; i++) begin
         drive(0, 0, 4'd0, 0);
         if (i == 15) check("to_before_limit", terr0, 0);
      end
      check("to_set", terr0, 1);
      check("to_req_held", req0, 1);
      beats = 0; dones = 0;
      for (int c = 0; c < 20; c++) begin
         drive(0, 0, 4'd0, 1);
         beats += int'(beat0);
         dones += int'(done0);
         if (dones != 0) break;
      end
      check("to_job_beats", beats, 2);
      check("to_job_done", dones, 1);
      repeat (3) drive(0, 0, 4'd0, 1);
      check("to_sticky", terr0, 1);
      drive(1, 0, 4'd0, 0);
      drive(0, 0, 4'd0, 0);
      check("to_cleared", terr0, 0);

      // reset mid-job after 2 of 8 beats
      drive(1, 0, 4'd0, 1);
      drive(0, 1, 4'd7, 1);
      beats = 0;
      for (int c = 0; c < 20 && beats < 2; c++) begin
         drive(0, 0, 4'd0, 1);
         beats += int'(beat0);
      end
      check("rmj_two_beats", beats, 2);
      drive(1, 0, 4'd0, 1);
      check("rmj_rst_beat", beat0, 0);
      check("rmj_rst_busy", busy0, 0);
      check("rmj_rst_ready", job_ready0, 1);
      drive(0, 0, 4'd0, 1);
      check("rmj_req", req0, 0);
      check("rmj_busy", busy0, 0);
      check("rmj_done", done0, 0);
      dones = 0; busy_seen = 0;
      for (int c = 0; c < 8; c++) begin
         drive(0, 0, 4'd0, 1);
         dones += int'(done0);
         busy_seen += int'(busy0);
      end
      check("rmj_no_done", dones, 0);
      check("rmj_queue_empty", busy_seen, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
